// File: rtl/regfile.sv
// Two-read, one-write register file: 32 x 32-bit, r0 hardwired to zero.
// Combinational reads with optional same-cycle write forwarding.
module regfile #(
   parameter int BYPASS = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_writeEnable,
   input  logic [4:0]  ctrl_writeRegister,
   input  logic [31:0] data_writeReg,
   input  logic [4:0]  ctrl_readRegA,
   input  logic [4:0]  ctrl_readRegB,
   output logic [31:0] data_readRegA,
   output logic [31:0] data_readRegB
);

   localparam bit Fwd = (BYPASS != 0);

   logic [31:0] rf [31:1];
   logic [31:1] wr_en;
   logic [31:0] stored_a;
   logic [31:0] stored_b;
   logic        fwd_ok;
   logic        hit_a;
   logic        hit_b;

   // One-hot write decode; address 0 has no enable, reset blocks all writes
   always_comb begin
      wr_en = '0;
      for (int i = 1; i < 32; i++) begin
         wr_en[i] = ctrl_writeEnable && !reset
                    && (ctrl_writeRegister == 5'(i));
      end
   end

   // Storage: per-register enabled flops, cleared asynchronously by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (wr_en[i]) begin
               rf[i] <= data_writeReg;
            end
         end
      end
   end

   // Port A 32:1 select; address 0 falls through to zero
   always_comb begin
      stored_a = '0;
      for (int i = 1; i < 32; i++) begin
         if (ctrl_readRegA == 5'(i)) begin
            stored_a = rf[i];
         end
      end
   end

   // Port B 32:1 select; address 0 falls through to zero
   always_comb begin
      stored_b = '0;
      for (int i = 1; i < 32; i++) begin
         if (ctrl_readRegB == 5'(i)) begin
            stored_b = rf[i];
         end
      end
   end

   // Forwarding qualifiers: only a live write to a nonzero register forwards
   always_comb begin
      fwd_ok = Fwd && ctrl_writeEnable && !reset
               && (ctrl_writeRegister != 5'd0);
      hit_a  = fwd_ok && (ctrl_readRegA == ctrl_writeRegister);
      hit_b  = fwd_ok && (ctrl_readRegB == ctrl_writeRegister);
   end

   // Output muxes: reset forces zero, then forward, then stored value
   always_comb begin
      data_readRegA = '0;
      data_readRegB = '0;
      if (!reset) begin
         data_readRegA = hit_a ? data_writeReg : stored_a;
         data_readRegB = hit_b ? data_writeReg : stored_b;
      end
   end

endmodule
